// File: rtl/cva6_cfg_reader_pkg.sv
// Types, word map and packing helpers for the read-only core configuration table.
// Fields are saturated into fixed 32-bit slots so software sees a stable layout per build.
package cva6_cfg_reader_pkg;

  typedef struct packed {
    logic [31:0] XLEN;
    logic [31:0] VLEN;
    logic [31:0] PLEN;
    logic [31:0] GPLEN;
    logic        RVA;
    logic        RVB;
    logic        RVC;
    logic        RVD;
    logic        RVF;
    logic        RVH;
    logic        RVS;
    logic        RVU;
    logic        RVV;
    logic        RVZCB;
    logic        RVZCMP;
    logic        RVZiCond;
    logic        RVZicntr;
    logic        RVZihpm;
    logic        XF16;
    logic        XF16ALT;
    logic        XF8;
    logic        XFVec;
    logic        CvxifEn;
    logic        ZKN;
    logic        DebugEn;
    logic        MmuPresent;
    logic        SuperscalarEn;
    logic        PerfCounterEn;
    logic [31:0] NrCommitPorts;
    logic [31:0] NrIssuePorts;
    logic [31:0] NrWbPorts;
    logic [31:0] NR_SB_ENTRIES;
    logic [31:0] FLen;
    logic [31:0] IcacheSetAssoc;
    logic [31:0] IcacheIndexWidth;
    logic [31:0] IcacheLineWidth;
    logic [31:0] DcacheSetAssoc;
    logic [31:0] DcacheIndexWidth;
    logic [31:0] DcacheLineWidth;
    logic [31:0] InstrTlbEntries;
    logic [31:0] DataTlbEntries;
    logic [31:0] SharedTlbDepth;
    logic [31:0] PtLevels;
    logic [31:0] RASDepth;
    logic [31:0] BTBEntries;
    logic [31:0] BHTEntries;
    logic [31:0] NrPMPEntries;
    logic [31:0] NrLoadBufEntries;
    logic [31:0] MaxOutstandingStores;
    logic [63:0] DmBaseAddress;
    logic [63:0] HaltAddress;
  } cva6_cfg_t;

  // cv64a6 imafdc sv39 flavour
  localparam cva6_cfg_t CVA6_CFG_DEFAULT = '{
    XLEN: 32'd64, VLEN: 32'd64, PLEN: 32'd56, GPLEN: 32'd41,
    RVA: 1'b1, RVB: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVH: 1'b0,
    RVS: 1'b1, RVU: 1'b1, RVV: 1'b0, RVZCB: 1'b1, RVZCMP: 1'b0,
    RVZiCond: 1'b1, RVZicntr: 1'b1, RVZihpm: 1'b1,
    XF16: 1'b0, XF16ALT: 1'b0, XF8: 1'b0, XFVec: 1'b0,
    CvxifEn: 1'b1, ZKN: 1'b1, DebugEn: 1'b1, MmuPresent: 1'b1,
    SuperscalarEn: 1'b0, PerfCounterEn: 1'b1,
    NrCommitPorts: 32'd2, NrIssuePorts: 32'd1, NrWbPorts: 32'd5,
    NR_SB_ENTRIES: 32'd8, FLen: 32'd64,
    IcacheSetAssoc: 32'd4, IcacheIndexWidth: 32'd12, IcacheLineWidth: 32'd128,
    DcacheSetAssoc: 32'd8, DcacheIndexWidth: 32'd12, DcacheLineWidth: 32'd128,
    InstrTlbEntries: 32'd16, DataTlbEntries: 32'd16, SharedTlbDepth: 32'd64,
    PtLevels: 32'd3,
    RASDepth: 32'd2, BTBEntries: 32'd32, BHTEntries: 32'd128,
    NrPMPEntries: 32'd8, NrLoadBufEntries: 32'd2, MaxOutstandingStores: 32'd7,
    DmBaseAddress: 64'h0000_0000_0000_0000,
    HaltAddress: 64'h0000_0000_0000_0800
  };

  localparam logic [31:0] CFG_MAGIC = 32'hC6A6_0001;

  localparam logic [3:0] CFG_W_MAGIC   = 4'd0;
  localparam logic [3:0] CFG_W_LEN     = 4'd1;
  localparam logic [3:0] CFG_W_EXT     = 4'd2;
  localparam logic [3:0] CFG_W_PORTS   = 4'd3;
  localparam logic [3:0] CFG_W_ICACHE  = 4'd4;
  localparam logic [3:0] CFG_W_DCACHE  = 4'd5;
  localparam logic [3:0] CFG_W_TLB     = 4'd6;
  localparam logic [3:0] CFG_W_BP      = 4'd7;
  localparam logic [3:0] CFG_W_BUF     = 4'd8;
  localparam logic [3:0] CFG_W_DM_LO   = 4'd9;
  localparam logic [3:0] CFG_W_DM_HI   = 4'd10;
  localparam logic [3:0] CFG_W_HALT_LO = 4'd11;
  localparam logic [3:0] CFG_W_HALT_HI = 4'd12;
  localparam logic [3:0] CFG_W_RSVD0   = 4'd13;
  localparam logic [3:0] CFG_W_RSVD1   = 4'd14;
  localparam logic [3:0] CFG_W_CHK     = 4'd15;

  typedef enum logic {
    ST_INIT,
    ST_SERVE
  } cfg_state_e;

  // Clamp v to the largest value representable in w bits.
  function automatic logic [31:0] sat(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    if (w >= 32) return v;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic cfg_err(input logic [3:0] idx);
    return (idx >= CFG_W_RSVD0) && (idx != CFG_W_CHK);
  endfunction

  // Checksum and reserved slots read as 0 here; the checksum is supplied by the reader.
  function automatic logic [31:0] cfg_word(input cva6_cfg_t c, input logic [3:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      CFG_W_MAGIC:   w = CFG_MAGIC;
      CFG_W_LEN:     w = sat(c.XLEN, 8) | (sat(c.VLEN, 8) << 8)
                       | (sat(c.PLEN, 8) << 16) | (sat(c.GPLEN, 8) << 24);
      CFG_W_EXT:     w = {8'h00, c.PerfCounterEn, c.SuperscalarEn, c.MmuPresent, c.DebugEn,
                          c.ZKN, c.CvxifEn, c.XFVec, c.XF8, c.XF16ALT, c.XF16,
                          c.RVZihpm, c.RVZicntr, c.RVZiCond, c.RVZCMP, c.RVZCB, c.RVV,
                          c.RVU, c.RVS, c.RVH, c.RVF, c.RVD, c.RVC, c.RVB, c.RVA};
      CFG_W_PORTS:   w = sat(c.NrCommitPorts, 4) | (sat(c.NrIssuePorts, 4) << 4)
                       | (sat(c.NrWbPorts, 4) << 8) | (sat(c.NR_SB_ENTRIES, 8) << 12)
                       | (sat(c.FLen, 8) << 20);
      CFG_W_ICACHE:  w = sat(c.IcacheSetAssoc, 8) | (sat(c.IcacheIndexWidth, 8) << 8)
                       | (sat(c.IcacheLineWidth, 16) << 16);
      CFG_W_DCACHE:  w = sat(c.DcacheSetAssoc, 8) | (sat(c.DcacheIndexWidth, 8) << 8)
                       | (sat(c.DcacheLineWidth, 16) << 16);
      CFG_W_TLB:     w = sat(c.InstrTlbEntries, 8) | (sat(c.DataTlbEntries, 8) << 8)
                       | (sat(c.SharedTlbDepth, 8) << 16) | (sat(c.PtLevels, 4) << 24);
      CFG_W_BP:      w = sat(c.RASDepth, 8) | (sat(c.BTBEntries, 8) << 8)
                       | (sat(c.BHTEntries, 16) << 16);
      CFG_W_BUF:     w = sat(c.NrPMPEntries, 8) | (sat(c.NrLoadBufEntries, 8) << 8)
                       | (sat(c.MaxOutstandingStores, 8) << 16);
      CFG_W_DM_LO:   w = c.DmBaseAddress[31:0];
      CFG_W_DM_HI:   w = c.DmBaseAddress[63:32];
      CFG_W_HALT_LO: w = c.HaltAddress[31:0];
      CFG_W_HALT_HI: w = c.HaltAddress[63:32];
      default:       w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/cva6_cfg_reader_if.sv
// Request/response bundle between a configuration table reader and its requester.
interface cva6_cfg_reader_if #(
  parameter int unsigned AddrW = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [AddrW-1:0] req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             init_done;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, init_done
  );
endinterface

// File: rtl/cva6_cfg_reader.sv
// Serves the packed core configuration table; 15-cycle checksum pass after reset, then 1-cycle read latency.
// One-entry response register: a stalled response holds its data and blocks new requests until consumed.
module cva6_cfg_reader
  import cva6_cfg_reader_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg  = CVA6_CFG_DEFAULT,
  parameter int unsigned NumWords = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  cva6_cfg_reader_if.slave         bus
);

  localparam int unsigned AddrW = $clog2(NumWords);

  cfg_state_e       state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;
  logic [31:0]      chk_q, chk_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             req_ready;
  logic             rd_err;

  assign rd_err = cfg_err(bus.req_addr);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;

    case (state_q)
      ST_INIT: begin
        chk_d = chk_q ^ cfg_word(CVA6Cfg, idx_q);
        idx_d = idx_q + AddrW'(1);
        if (idx_q == CFG_W_RSVD1) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        req_ready = ~rsp_valid_q | bus.rsp_ready;
        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
        // A same-cycle consume and accept simply reloads the register.
        if (bus.req_valid && req_ready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = rd_err;
          if (rd_err)                         rsp_data_d = '0;
          else if (bus.req_addr == CFG_W_CHK) rsp_data_d = chk_q;
          else                                rsp_data_d = cfg_word(CVA6Cfg, bus.req_addr);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      chk_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_done = (state_q == ST_SERVE);

endmodule

// File: tb/tb_cva6_cfg_reader.sv
// Bench for cva6_cfg_reader: default and saturating configurations side by side.
module tb_cva6_cfg_reader;
  import cva6_cfg_reader_pkg::*;

  function automatic cva6_cfg_t mk_sat_cfg();
    cva6_cfg_t c;
    c            = CVA6_CFG_DEFAULT;
    c.BHTEntries = 32'h0001_0000;
    c.XLEN       = 32'd300;
    return c;
  endfunction

  localparam cva6_cfg_t CFG_SAT = mk_sat_cfg();

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        req_valid [2];
  logic [3:0]  req_addr  [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        init_done [2];

  cva6_cfg_reader_if #(.AddrW(4)) ifa ();
  cva6_cfg_reader_if #(.AddrW(4)) ifb ();

  assign ifa.req_valid = req_valid[0];
  assign ifa.req_addr  = req_addr[0];
  assign ifa.rsp_ready = rsp_ready[0];
  assign ifb.req_valid = req_valid[1];
  assign ifb.req_addr  = req_addr[1];
  assign ifb.rsp_ready = rsp_ready[1];
  assign req_ready[0] = ifa.req_ready;
  assign rsp_valid[0] = ifa.rsp_valid;
  assign rsp_data[0]  = ifa.rsp_data;
  assign rsp_err[0]   = ifa.rsp_err;
  assign init_done[0] = ifa.init_done;
  assign req_ready[1] = ifb.req_ready;
  assign rsp_valid[1] = ifb.rsp_valid;
  assign rsp_data[1]  = ifb.rsp_data;
  assign rsp_err[1]   = ifb.rsp_err;
  assign init_done[1] = ifb.init_done;

  cva6_cfg_reader #(.CVA6Cfg(CVA6_CFG_DEFAULT), .NumWords(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa)
  );
  cva6_cfg_reader #(.CVA6Cfg(CFG_SAT), .NumWords(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: each slot is min(field, 2^bits-1) scaled to its bit offset.
  function automatic logic [63:0] clip(input logic [31:0] v, input int bits);
    logic [63:0] lim;
    lim = (64'd1 << bits) - 64'd1;
    return ({32'd0, v} > lim) ? lim : {32'd0, v};
  endfunction

  function automatic logic [31:0] exp_word(input cva6_cfg_t c, input int i);
    logic [63:0] s;
    bit e [24];
    s = 64'd0;
    case (i)
      0: s = 64'hC6A6_0001;
      1: s = clip(c.XLEN, 8) + clip(c.VLEN, 8) * 64'd256 + clip(c.PLEN, 8) * 64'd65536
           + clip(c.GPLEN, 8) * 64'd16777216;
      2: begin
        e = '{c.RVA, c.RVB, c.RVC, c.RVD, c.RVF, c.RVH, c.RVS, c.RVU, c.RVV, c.RVZCB,
              c.RVZCMP, c.RVZiCond, c.RVZicntr, c.RVZihpm, c.XF16, c.XF16ALT, c.XF8,
              c.XFVec, c.CvxifEn, c.ZKN, c.DebugEn, c.MmuPresent, c.SuperscalarEn,
              c.PerfCounterEn};
        for (int k = 0; k < 24; k++) if (e[k]) s = s + (64'd1 << k);
      end
      3: s = clip(c.NrCommitPorts, 4) + clip(c.NrIssuePorts, 4) * 64'd16
           + clip(c.NrWbPorts, 4) * 64'd256 + clip(c.NR_SB_ENTRIES, 8) * 64'd4096
           + clip(c.FLen, 8) * 64'd1048576;
      4: s = clip(c.IcacheSetAssoc, 8) + clip(c.IcacheIndexWidth, 8) * 64'd256
           + clip(c.IcacheLineWidth, 16) * 64'd65536;
      5: s = clip(c.DcacheSetAssoc, 8) + clip(c.DcacheIndexWidth, 8) * 64'd256
           + clip(c.DcacheLineWidth, 16) * 64'd65536;
      6: s = clip(c.InstrTlbEntries, 8) + clip(c.DataTlbEntries, 8) * 64'd256
           + clip(c.SharedTlbDepth, 8) * 64'd65536 + clip(c.PtLevels, 4) * 64'd16777216;
      7: s = clip(c.RASDepth, 8) + clip(c.BTBEntries, 8) * 64'd256
           + clip(c.BHTEntries, 16) * 64'd65536;
      8: s = clip(c.NrPMPEntries, 8) + clip(c.NrLoadBufEntries, 8) * 64'd256
           + clip(c.MaxOutstandingStores, 8) * 64'd65536;
      9:  s = c.DmBaseAddress % 64'h1_0000_0000;
      10: s = c.DmBaseAddress / 64'h1_0000_0000;
      11: s = c.HaltAddress % 64'h1_0000_0000;
      12: s = c.HaltAddress / 64'h1_0000_0000;
      15: for (int k = 0; k < 15; k++) s = s ^ {32'd0, exp_word(c, k)};
      default: s = 64'd0;
    endcase
    return s[31:0];
  endfunction

  function automatic logic exp_err(input int i);
    return (i == 13) || (i == 14);
  endfunction

  function automatic cva6_cfg_t cfg_of(input int d);
    return (d == 0) ? CVA6_CFG_DEFAULT : CFG_SAT;
  endfunction

  // Called just after rst_i drops at a falling edge; INIT must last exactly 15 cycles.
  task automatic init_check();
    for (int cyc = 1; cyc <= 15; cyc++) begin
      #1;
      check($sformatf("init_busy_c%0d", cyc),
            32'({req_ready[0], rsp_valid[0], init_done[0], req_ready[1], rsp_valid[1], init_done[1]}),
            32'd0);
      @(negedge clk);
    end
    #1;
    check("init_done_c16", 32'({init_done[0], init_done[1]}), 32'd3);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b1;
      req_addr[d]  = 4'd0;
      rsp_ready[d] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", 32'({req_ready[0], rsp_valid[0], rsp_err[0], init_done[0]}), 32'd0);
    check("reset_data", rsp_data[0], 32'd0);
    rst = 1'b0;
    init_check();
  endtask

  task automatic read1(input int d, input int a, output logic [31:0] data);
    req_valid[d] = 1'b1;
    req_addr[d]  = 4'(a);
    rsp_ready[d] = 1'b1;
    #1;
    check($sformatf("rd_rdy_d%0d_a%0d", d, a), 32'(req_ready[d]), 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    #1;
    check($sformatf("rd_vld_d%0d_a%0d", d, a), 32'(rsp_valid[d]), 32'd1);
    check($sformatf("rd_dat_d%0d_a%0d", d, a), rsp_data[d], exp_word(cfg_of(d), a));
    check($sformatf("rd_err_d%0d_a%0d", d, a), 32'(rsp_err[d]), 32'(exp_err(a)));
    data = rsp_data[d];
  endtask

  task automatic stall_test();
    req_valid[0] = 1'b1;
    req_addr[0]  = 4'd2;
    rsp_ready[0] = 1'b0;
    #1;
    check("st_acc2", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_addr[0] = 4'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_hold_vld", 32'(rsp_valid[0]), 32'd1);
      check("st_hold_dat", rsp_data[0], exp_word(CVA6_CFG_DEFAULT, 2));
      check("st_hold_rdy", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    #1;
    check("st_rel_dat", rsp_data[0], exp_word(CVA6_CFG_DEFAULT, 2));
    check("st_rel_rdy", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_addr[0] = 4'd4;
    #1;
    check("st_dat3", rsp_data[0], exp_word(CVA6_CFG_DEFAULT, 3));
    check("st_vld3", 32'(rsp_valid[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    check("st_dat4", rsp_data[0], exp_word(CVA6_CFG_DEFAULT, 4));
    @(negedge clk);
    #1;
    check("st_drain", 32'(rsp_valid[0]), 32'd0);
  endtask

  task automatic random_run(input int d, input int n);
    logic        mv, me, er;
    logic [31:0] md;
    mv = 1'b0;
    me = 1'b0;
    md = '0;
    for (int i = 0; i < n; i++) begin
      req_valid[d] = 1'($urandom_range(0, 1));
      req_addr[d]  = 4'($urandom_range(0, 15));
      rsp_ready[d] = ($urandom_range(0, 3) != 0);
      #1;
      er = !mv || rsp_ready[d];
      check("rnd_rdy", 32'(req_ready[d]), 32'(er));
      check("rnd_vld", 32'(rsp_valid[d]), 32'(mv));
      if (mv) begin
        check("rnd_dat", rsp_data[d], md);
        check("rnd_err", 32'(rsp_err[d]), 32'(me));
      end
      if (mv && rsp_ready[d]) mv = 1'b0;
      if (req_valid[d] && er) begin
        mv = 1'b1;
        md = exp_word(cfg_of(d), int'(req_addr[d]));
        me = exp_err(int'(req_addr[d]));
      end
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_addr[k]  = 4'd0;
      rsp_ready[k] = 1'b1;
    end
    @(negedge clk);
    do_reset();

    read1(0, 0, d);
    check("magic", d, 32'hC6A6_0001);
    read1(0, 1, d);
    check("xlen", d & 32'hFF, 32'd64);
    check("plen", (d >> 16) & 32'hFF, 32'd56);
    read1(0, 13, d);
    read1(0, 14, d);
    read1(0, 15, d);
    read1(1, 7, d);
    check("bht_sat", d >> 16, 32'h0000_FFFF);
    read1(1, 1, d);
    check("xlen_sat", d & 32'hFF, 32'hFF);
    @(negedge clk);
    #1;
    check("drain", 32'({rsp_valid[0], rsp_valid[1]}), 32'd0);

    stall_test();
    random_run(0, 250);
    random_run(1, 250);

    // Reset with a response pending.
    req_valid[0] = 1'b1;
    req_addr[0]  = 4'd5;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    check("pend_vld", 32'(rsp_valid[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_drop", 32'({rsp_valid[0], init_done[0]}), 32'd0);
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    check("init_ignores_req", 32'({req_ready[0], rsp_valid[0], req_ready[1], rsp_valid[1]}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_init", 32'({rsp_valid[0], init_done[0], rsp_valid[1], init_done[1]}), 32'd0);
    rst = 1'b0;
    init_check();
    read1(0, 15, d);
    read1(1, 15, d);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
